// File: rtl/ipm_fifo_rd_stream_pkg.sv
// Shared constants and sizing helpers for the FIFO read-side stream adapter.
package ipm_fifo_rd_stream_pkg;

  localparam int unsigned c_RD_LATENCY_MIN = 1;
  localparam int unsigned c_RD_LATENCY_MAX = 2;

  // One extra entry beyond the read latency lets a word land while the head waits.
  function automatic int unsigned buf_depth(input int unsigned rd_latency);
    return rd_latency + 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ipm_fifo_rd_skid_buf.sv
// Circular skid buffer holding words returned by the FIFO memory until the stream accepts them.
module ipm_fifo_rd_skid_buf
  import ipm_fifo_rd_stream_pkg::*;
#(
  parameter int unsigned c_DATA_WIDTH = 32,
  parameter int unsigned c_DEPTH      = 2,
  parameter int unsigned c_CNT_W      = cnt_width(c_DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic [c_DATA_WIDTH-1:0] push_data_i,
  input  logic                    pop_i,
  output logic [c_DATA_WIDTH-1:0] head_o,
  output logic [c_CNT_W-1:0]      cnt_o
);

  localparam int unsigned c_IDX_W = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_DEPTH - 1);

  logic [c_DATA_WIDTH-1:0] mem_q [c_DEPTH];
  logic [c_IDX_W-1:0]      rd_idx_q, rd_idx_d;
  logic [c_IDX_W-1:0]      wr_idx_q, wr_idx_d;
  logic [c_CNT_W-1:0]      cnt_q, cnt_d;

  // Depth is generally not a power of two, so the wrap is explicit.
  function automatic logic [c_IDX_W-1:0] next_idx(input logic [c_IDX_W-1:0] idx);
    return (idx == c_LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    rd_idx_d = pop_i  ? next_idx(rd_idx_q) : rd_idx_q;
    wr_idx_d = push_i ? next_idx(wr_idx_q) : wr_idx_q;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_idx_q <= '0;
      wr_idx_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < c_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_idx_q <= rd_idx_d;
      wr_idx_q <= wr_idx_d;
      cnt_q    <= cnt_d;
      if (push_i) mem_q[wr_idx_q] <= push_data_i;
    end
  end

  assign head_o = mem_q[rd_idx_q];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/ipm_fifo_rd_stream.sv
// FIFO read-side consumer presenting memory data as a first-word-fall-through stream.
// Optional FIFO_RD_STREAM_STALL_CNT_EN adds a saturating stall_cnt output.
module ipm_fifo_rd_stream
  import ipm_fifo_rd_stream_pkg::*;
#(
  parameter int unsigned c_DATA_WIDTH = 32,
  parameter int unsigned c_RD_LATENCY = 1
) (
  input  logic                    rclk,
  input  logic                    rrst,
  input  logic                    fifo_rempty,
  output logic                    fifo_rd_en,
  input  logic [c_DATA_WIDTH-1:0] fifo_rd_data,
  output logic                    m_valid,
  output logic [c_DATA_WIDTH-1:0] m_data,
  input  logic                    m_ready,
  output logic [cnt_width(buf_depth(c_RD_LATENCY))-1:0] buf_cnt
`ifdef FIFO_RD_STREAM_STALL_CNT_EN
  ,
  output logic [15:0]             stall_cnt
`endif
);

  localparam int unsigned c_BUF_DEPTH = buf_depth(c_RD_LATENCY);
  localparam int unsigned c_CNT_W     = cnt_width(c_BUF_DEPTH);

  if (c_RD_LATENCY < c_RD_LATENCY_MIN || c_RD_LATENCY > c_RD_LATENCY_MAX) begin : g_bad_latency
    $error("ipm_fifo_rd_stream: c_RD_LATENCY must be 1 or 2");
  end

  // Stream handshake: a beat transfers on any cycle with m_valid && m_ready; once
  // m_valid is high, m_valid and m_data hold until that transfer happens.
  logic                     pop;
  logic                     push;
  logic [c_RD_LATENCY-1:0]  vld_q, vld_d;
  logic [c_CNT_W-1:0]       inflight;
  logic [c_CNT_W:0]         occ;
  logic [c_CNT_W:0]         limit;

  assign pop  = m_valid && m_ready;
  assign push = vld_q[c_RD_LATENCY-1];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < c_RD_LATENCY; i++) inflight = inflight + c_CNT_W'(vld_q[i]);
  end

  // Reserve a buffer slot for every read in flight so a returning word always fits.
  assign occ        = {1'b0, inflight} + {1'b0, buf_cnt};
  assign limit      = (c_CNT_W + 1)'(c_BUF_DEPTH) + {{c_CNT_W{1'b0}}, pop};
  assign fifo_rd_en = !rrst && !fifo_rempty && (occ < limit);
  assign vld_d      = c_RD_LATENCY'({vld_q, fifo_rd_en});

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) vld_q <= '0;
    else      vld_q <= vld_d;
  end

  ipm_fifo_rd_skid_buf #(
    .c_DATA_WIDTH (c_DATA_WIDTH),
    .c_DEPTH      (c_BUF_DEPTH),
    .c_CNT_W      (c_CNT_W)
  ) u_skid_buf (
    .clk_i       (rclk),
    .rst_i       (rrst),
    .push_i      (push),
    .push_data_i (fifo_rd_data),
    .pop_i       (pop),
    .head_o      (m_data),
    .cnt_o       (buf_cnt)
  );

  assign m_valid = (buf_cnt != '0);

`ifdef FIFO_RD_STREAM_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst)                                        stall_q <= '0;
    else if (pop && buf_cnt == c_CNT_W'(1))          stall_q <= '0;
    else if (m_valid && !m_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`endif

endmodule
